// File: rtl/rs_sum_pkg.sv
// Shared BO parameters: default operand width and control-word (y) bit indices,
// common to the ks1 stage and rs_sum.
package rs_sum_pkg;

    localparam int N_DEFAULT = 4;

    // Bit positions of the BO control signals within the control word.
    localparam int Y4 = 4;
    localparam int Y5 = 5;
    localparam int Y6 = 6;
    localparam int Y7 = 7;
    localparam int Y8 = 8;

    // Width of an iteration counter that must hold values 0..n.
    function automatic int cnt_width(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/rs_sum_sm2n.sv
// Signed adder over W-bit operands producing the true W+1-bit sum and the
// W-bit two's-complement overflow indication.
module sm2n #(
    parameter int W = 8
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W:0]   sum,
    output logic         ovf
);

    assign sum = {a[W-1], a} + {b[W-1], b};

    // Overflow of the wrapped W-bit result: same operand signs, different result sign.
    assign ovf = (a[W-1] == b[W-1]) && (sum[W-1] != a[W-1]);

endmodule

// File: rtl/rs_sum.sv
// RS accumulator: clear / add / arithmetic-shift with a sticky overflow flag
// and a saturating-at-zero iteration counter.
module rs_sum
    import rs_sum_pkg::*;
#(
    parameter int N = N_DEFAULT
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [2*N-1:0] ks1_in,
    input  logic           y6,
    input  logic           y7,
    input  logic           y8,
    output logic [2*N-1:0] rs,
    output logic           p_sign,
    output logic           p_zero,
    output logic           p_ovf,
    output logic           p_cnt0
);

    localparam int W  = 2 * N;
    localparam int CW = cnt_width(N);

    logic [Y8:Y6] ctl;
    logic [W:0]   sum;
    logic         add_ovf;
    logic [CW-1:0] cnt;

    assign ctl = {y8, y7, y6};

    sm2n #(.W(W)) u_sm2n (
        .a   (rs),
        .b   (ks1_in),
        .sum (sum),
        .ovf (add_ovf)
    );

    // NOTE: all state is written with non-blocking assignments so every register
    // samples the pre-edge values of rs and cnt, matching the hardware it models.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rs    <= '0;
            p_ovf <= 1'b0;
            cnt   <= '0;
        end else if (ctl[Y6]) begin
            rs    <= '0;
            p_ovf <= 1'b0;
            cnt   <= CW'(N);
        end else begin
            unique case ({ctl[Y7], ctl[Y8]})
                2'b10: begin
                    rs <= sum[W-1:0];
                    if (add_ovf) p_ovf <= 1'b1;
                end
                2'b01: rs <= {rs[W-1], rs[W-1:1]};
                // Add-then-shift keeps the true sign from the W+1-bit sum, so it cannot overflow.
                2'b11: rs <= sum[W:1];
                default: ;
            endcase
            if (ctl[Y8] && (cnt != '0)) cnt <= cnt - CW'(1);
        end
    end

    assign p_sign = rs[W-1];
    assign p_zero = (rs == '0);
    assign p_cnt0 = (cnt == '0);

endmodule

// File: tb/tb_rs_sum.sv
// Directed scoreboard bench for rs_sum (N=4): the driver queues expected state
// after each edge, the monitor pops and compares on the following falling edge.
module tb_rs_sum;

    localparam int N = 4;
    localparam int W = 2 * N;

    typedef struct {
        string      name;
        logic [7:0] rs;
        logic       ovf;
        int         cnt;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [W-1:0] ks1_in = '0;
    logic         y6 = 1'b0, y7 = 1'b0, y8 = 1'b0;
    logic [W-1:0] rs;
    logic         p_sign, p_zero, p_ovf, p_cnt0;

    int   n_tests = 0;
    int   n_fail  = 0;
    exp_t sb[$];

    rs_sum #(.N(N)) dut (
        .clk    (clk),
        .rst    (rst),
        .ks1_in (ks1_in),
        .y6     (y6),
        .y7     (y7),
        .y8     (y8),
        .rs     (rs),
        .p_sign (p_sign),
        .p_zero (p_zero),
        .p_ovf  (p_ovf),
        .p_cnt0 (p_cnt0)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    task automatic check_state(input string name, input logic [7:0] e_rs, input logic e_ovf, input int e_cnt);
        check({name, ".rs"},     32'(rs),         32'(e_rs));
        check({name, ".p_ovf"},  32'(p_ovf),      32'(e_ovf));
        check({name, ".cnt"},    32'(dut.cnt),    32'(e_cnt));
        check({name, ".p_zero"}, 32'(p_zero),     32'(e_rs == 8'h00));
        check({name, ".p_sign"}, 32'(p_sign),     32'(e_rs[7]));
        check({name, ".p_cnt0"}, 32'(p_cnt0),     32'(e_cnt == 0));
    endtask

    // Monitor: compares DUT state against the oldest queued expectation.
    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            check_state(e.name, e.rs, e.ovf, e.cnt);
        end
    end

    task automatic op(input string name, input logic c6, input logic c7, input logic c8,
                      input logic [7:0] ks, input logic [7:0] e_rs, input logic e_ovf, input int e_cnt);
        exp_t e;
        @(negedge clk);
        y6 = c6; y7 = c7; y8 = c8; ks1_in = ks;
        @(posedge clk);
        #1;
        e.name = name; e.rs = e_rs; e.ovf = e_ovf; e.cnt = e_cnt;
        sb.push_back(e);
        y6 = 1'b0; y7 = 1'b0; y8 = 1'b0; ks1_in = '0;
    endtask

    // Asynchronous reset pulse placed between clock edges.
    task automatic async_reset(input string name);
        @(posedge clk);
        #2 rst = 1'b1;
        #1 check_state(name, 8'h00, 1'b0, 0);
        #1 rst = 1'b0;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1 check_state("por", 8'h00, 1'b0, 0);
        @(negedge clk) rst = 1'b0;

        // Clear then add a negative operand.
        op("clr0",   1, 0, 0, 8'h00, 8'h00, 0, 4);
        op("add_fd", 0, 1, 0, 8'hFD, 8'hFD, 0, 4);
        op("idle",   0, 0, 0, 8'h33, 8'hFD, 0, 4);
        async_reset("rst_async");

        // Sticky overflow.
        op("clr1",   1, 0, 0, 8'h00, 8'h00, 0, 4);
        op("add_7f", 0, 1, 0, 8'h7F, 8'h7F, 0, 4);
        op("ovf",    0, 1, 0, 8'h01, 8'h80, 1, 4);
        op("ovf_hold", 0, 1, 0, 8'h00, 8'h80, 1, 4);
        op("ovf_clr", 1, 0, 0, 8'h00, 8'h00, 0, 4);

        // Wrap without overflow: FF + 01.
        op("add_ff", 0, 1, 0, 8'hFF, 8'hFF, 0, 4);
        op("wrap",   0, 1, 0, 8'h01, 8'h00, 0, 4);

        // Shift and count down, counter saturates at 0.
        op("clr2",   1, 0, 0, 8'h00, 8'h00, 0, 4);
        op("ld_f8",  0, 1, 0, 8'hF8, 8'hF8, 0, 4);
        op("sh1",    0, 0, 1, 8'h00, 8'hFC, 0, 3);
        op("sh2",    0, 0, 1, 8'h00, 8'hFE, 0, 2);
        op("sh3",    0, 0, 1, 8'h00, 8'hFF, 0, 1);
        op("sh4",    0, 0, 1, 8'h00, 8'hFF, 0, 0);
        op("sh5",    0, 0, 1, 8'h00, 8'hFF, 0, 0);

        // Combined add+shift uses the true 9-bit sum sign; clear dominates.
        op("clr3",   1, 0, 0, 8'h00, 8'h00, 0, 4);
        op("ld_7f",  0, 1, 0, 8'h7F, 8'h7F, 0, 4);
        op("addsh",  0, 1, 1, 8'h7F, 8'h7F, 0, 3);
        op("addsh_neg", 0, 1, 1, 8'h81, 8'h00, 0, 2);
        op("addsh_nn", 0, 1, 1, 8'h80, 8'hC0, 0, 1);
        op("all3",   1, 1, 1, 8'h55, 8'h00, 0, 4);

        // Reset in the middle of a shift sequence.
        op("ld_f8b", 0, 1, 0, 8'hF8, 8'hF8, 0, 4);
        op("shb1",   0, 0, 1, 8'h00, 8'hFC, 0, 3);
        async_reset("rst_mid");
        op("sh_post", 0, 0, 1, 8'h00, 8'h00, 0, 0);

        repeat (2) @(negedge clk);
        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
